// File: rtl/ldpc_frame_ctrl.sv
// Frame sequencer for ldpc_core: loads one LLR frame, clears and runs the core up to an iteration cap,
// then streams the captured hard decisions. Define LDPC_CTRL_STATS_EN to add stat_iter/stat_conv ports.
module ldpc_frame_ctrl #(
  parameter int DATA_W   = 5,
  parameter int N_BITS   = 2304,
  parameter int LLR_PB   = 16,
  parameter int OUT_W    = 64,
  parameter int MAX_ITER = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [LLR_PB*DATA_W-1:0] s_data,
  input  logic                     s_last,
  output logic                     core_rst,
  output logic                     core_en,
  output logic [N_BITS*DATA_W-1:0] core_l,
  input  logic                     core_term,
  input  logic [N_BITS-1:0]        core_res,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [OUT_W-1:0]         m_data,
  output logic                     m_last,
  output logic                     frm_err,
  output logic                     busy
`ifdef LDPC_CTRL_STATS_EN
  ,
  output logic [7:0]               stat_iter,
  output logic                     stat_conv
`endif
);
  localparam int BEAT_W = LLR_PB * DATA_W;
  localparam int L_W    = N_BITS * DATA_W;
  localparam int N_IN   = N_BITS / LLR_PB;
  localparam int N_OUT  = N_BITS / OUT_W;
  localparam int K_W    = $clog2(N_IN + 1);
  localparam int J_W    = $clog2(N_OUT + 1);
  localparam int OFF_W  = $clog2(L_W);
  localparam logic [K_W-1:0] K_LAST   = K_W'(N_IN - 1);
  localparam logic [J_W-1:0] J_LAST   = J_W'(N_OUT - 1);
  localparam logic [7:0]     ITER_CAP = 8'(MAX_ITER);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [K_W-1:0]    k_q;
  logic [J_W-1:0]    j_q;
  logic [7:0]        iter_q;
  logic [L_W-1:0]    l_q;
  logic [N_BITS-1:0] res_q;
  logic              s_ready_q, core_rst_q, core_en_q, m_valid_q, m_last_q, frm_err_q, busy_q;
`ifdef LDPC_CTRL_STATS_EN
  logic [7:0]        stat_iter_q;
  logic              stat_conv_q;
`endif

  logic              s_acc, m_acc, frame_ok, frame_bad, run_exit;
  logic [7:0]        iter_nxt;
  logic [OFF_W-1:0]  l_off;

  assign s_acc     = s_valid & s_ready_q;
  assign m_acc     = m_valid_q & m_ready;
  assign frame_ok  = s_acc & (k_q == K_LAST) & s_last;
  // s_last must coincide exactly with the final beat index; either mismatch discards the frame
  assign frame_bad = s_acc & ((k_q == K_LAST) ^ s_last);
  assign iter_nxt  = iter_q + 8'd1;
  assign run_exit  = core_term | (iter_nxt == ITER_CAP);
  assign l_off     = OFF_W'(k_q) * OFF_W'(BEAT_W);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (frame_ok)       state_d = ST_CLEAR;
        else if (frame_bad) state_d = ST_IDLE;
        else if (s_acc)     state_d = ST_LOAD;
      end
      ST_CLEAR: state_d = ST_RUN;
      ST_RUN:   if (run_exit) state_d = ST_DRAIN;
      ST_DRAIN: if (m_acc && (j_q == J_LAST)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      j_q         <= '0;
      iter_q      <= '0;
      l_q         <= '0;
      res_q       <= '0;
      s_ready_q   <= 1'b0;
      core_rst_q  <= 1'b1;
      core_en_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      frm_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef LDPC_CTRL_STATS_EN
      stat_iter_q <= '0;
      stat_conv_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      s_ready_q  <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
      core_rst_q <= (state_d != ST_RUN);
      core_en_q  <= (state_d == ST_RUN);
      m_valid_q  <= (state_d == ST_DRAIN);
      busy_q     <= (state_d != ST_IDLE);
      frm_err_q  <= frame_bad;

      if (s_acc) begin
        l_q[l_off +: BEAT_W] <= s_data;
        k_q <= (frame_ok || frame_bad) ? '0 : k_q + K_W'(1);
      end

      if (state_q == ST_CLEAR) iter_q <= '0;

      // Decisions are frozen at RUN exit so the core can be held in reset while draining
      if (state_q == ST_RUN) begin
        iter_q <= iter_nxt;
        if (run_exit) begin
          res_q    <= core_res;
          j_q      <= '0;
          m_last_q <= (N_OUT == 1);
`ifdef LDPC_CTRL_STATS_EN
          stat_iter_q <= iter_nxt;
          stat_conv_q <= core_term;
`endif
        end
      end

      if ((state_q == ST_DRAIN) && m_acc) begin
        res_q <= res_q >> OUT_W;
        if (j_q == J_LAST) begin
          j_q      <= '0;
          m_last_q <= 1'b0;
        end else begin
          j_q      <= j_q + J_W'(1);
          m_last_q <= ((j_q + J_W'(1)) == J_LAST);
        end
      end

      if (state_d == ST_IDLE) begin
        k_q    <= '0;
        j_q    <= '0;
        iter_q <= '0;
      end
    end
  end

  assign s_ready  = s_ready_q;
  assign core_rst = core_rst_q;
  assign core_en  = core_en_q;
  assign core_l   = l_q;
  assign m_valid  = m_valid_q;
  assign m_data   = res_q[OUT_W-1:0];
  assign m_last   = m_last_q;
  assign frm_err  = frm_err_q;
  assign busy     = busy_q;
`ifdef LDPC_CTRL_STATS_EN
  assign stat_iter = stat_iter_q;
  assign stat_conv = stat_conv_q;
`endif

endmodule

// File: tb/tb_ldpc_frame_ctrl.sv
// Bench for ldpc_frame_ctrl: random LLR frames and decisions, a behavioural core stand-in, and
// per-scenario checks of load, iteration cap, framing errors, backpressure and back-to-back frames.
module tb_ldpc_frame_ctrl;
  localparam int DATA_W   = 5;
  localparam int N_BITS   = 2304;
  localparam int LLR_PB   = 16;
  localparam int OUT_W    = 64;
  localparam int MAX_ITER = 40;
  localparam int NB_IN    = N_BITS / LLR_PB;
  localparam int NB_OUT   = N_BITS / OUT_W;

  logic clk, rst, s_valid, s_ready, s_last, core_rst, core_en, core_term;
  logic m_valid, m_ready, m_last, frm_err, busy;
  logic [LLR_PB*DATA_W-1:0] s_data;
  logic [N_BITS*DATA_W-1:0] core_l;
  logic [N_BITS-1:0]        core_res;
  logic [OUT_W-1:0]         m_data;
`ifdef LDPC_CTRL_STATS_EN
  logic [7:0] stat_iter;
  logic       stat_conv;
`endif

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] llr [2][N_BITS];
  logic [N_BITS-1:0] res_v [2];

  ldpc_frame_ctrl #(
    .DATA_W(DATA_W), .N_BITS(N_BITS), .LLR_PB(LLR_PB), .OUT_W(OUT_W), .MAX_ITER(MAX_ITER)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .core_rst(core_rst), .core_en(core_en), .core_l(core_l),
    .core_term(core_term), .core_res(core_res),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .frm_err(frm_err), .busy(busy)
`ifdef LDPC_CTRL_STATS_EN
    , .stat_iter(stat_iter), .stat_conv(stat_conv)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill_frame(input int f);
    for (int i = 0; i < N_BITS; i++) llr[f][i] = DATA_W'($urandom);
    for (int w = 0; w < N_BITS / 32; w++) res_v[f][w*32 +: 32] = $urandom;
  endtask

  function automatic logic [N_BITS*DATA_W-1:0] exp_l(input int f);
    logic [N_BITS*DATA_W-1:0] v;
    for (int i = 0; i < N_BITS; i++) v[i*DATA_W +: DATA_W] = llr[f][i];
    return v;
  endfunction

  task automatic drive_beat(input int f, input int b, input bit last);
    for (int lane = 0; lane < LLR_PB; lane++)
      s_data[lane*DATA_W +: DATA_W] = llr[f][b*LLR_PB + lane];
    s_valid = 1'b1;
    s_last  = last;
  endtask

  // Called at a negedge; returns at the negedge after the final beat was taken.
  task automatic send_frame(input int f, input int nbeats, input int last_at, input bit hold, input int nf);
    int b = 0;
    int guard = 0;
    while (b < nbeats && guard < 1000) begin
      drive_beat(f, b, b == last_at);
      if (s_ready === 1'b1) b++;
      @(negedge clk);
      guard++;
    end
    total++;
    if (guard >= 1000) begin
      bad++;
      $display("FAIL send_timeout: beats taken %0d required %0d", b, nbeats);
    end
    if (hold) drive_beat(nf, 0, 1'b0);
    else begin
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic check_loaded(input int f, input string tag);
    logic [N_BITS*DATA_W-1:0] e;
    e = exp_l(f);
    total++;
    if (core_l !== e) begin
      int idx = -1;
      for (int i = N_BITS - 1; i >= 0; i--)
        if (core_l[i*DATA_W +: DATA_W] !== e[i*DATA_W +: DATA_W]) idx = i;
      bad++;
      $display("FAIL %s core_l: first bad LLR %0d got %h exp %h", tag, idx,
               (idx >= 0) ? core_l[idx*DATA_W +: DATA_W] : 5'h0, (idx >= 0) ? e[idx*DATA_W +: DATA_W] : 5'h0);
    end
    total++;
    if (core_rst !== 1'b1 || core_en !== 1'b0 || s_ready !== 1'b0 || frm_err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s clear_cycle: rst=%b en=%b rdy=%b err=%b busy=%b exp 1 0 0 0 1", tag,
               core_rst, core_en, s_ready, frm_err, busy);
    end
  endtask

  // Stand-in core: raises term during the term_at-th enabled cycle (0 = never).
  task automatic run_core(input int f, input int term_at, output int n);
    int guard = 0;
    bit side_ok = 1'b1;
    n = 0;
    core_res  = res_v[f];
    core_term = 1'b0;
    do begin
      @(negedge clk);
      guard++;
      if (core_en === 1'b1) begin
        n++;
        core_term = (n == term_at);
        if (core_rst !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b0) side_ok = 1'b0;
      end
    end while ((n == 0 || core_en === 1'b1) && guard < 300);
    core_term = 1'b0;
    core_res  = ~res_v[f];
    total++;
    if (guard >= 300 || !side_ok) begin
      bad++;
      $display("FAIL run_phase: guard=%0d side_ok=%0d exp guard<300 side_ok=1", guard, side_ok);
    end
  endtask

  task automatic drain(input int f, input bit bp, input string tag);
    int got = 0;
    int guard = 0;
    bit stalled = 1'b0;
    bit side_ok = 1'b1;
    logic [OUT_W-1:0] pd;
    logic pl;
    pd = '0;
    pl = 1'b0;
    while (got < NB_OUT && guard < 2000) begin
      m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_ready !== 1'b0 || core_en !== 1'b0 || core_rst !== 1'b1) side_ok = 1'b0;
      if (m_valid === 1'b1) begin
        if (stalled) begin
          total++;
          if (m_data !== pd || m_last !== pl) begin
            bad++;
            $display("FAIL %s stall_hold beat %0d: got %h/%b exp %h/%b", tag, got, m_data, m_last, pd, pl);
          end
        end
        if (m_ready) begin
          total++;
          if (m_data !== res_v[f][got*OUT_W +: OUT_W] || m_last !== (got == NB_OUT - 1)) begin
            bad++;
            $display("FAIL %s out_beat %0d: got %h last=%b exp %h last=%b", tag, got, m_data, m_last,
                     res_v[f][got*OUT_W +: OUT_W], got == NB_OUT - 1);
          end
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          pd = m_data;
          pl = m_last;
        end
      end
      @(negedge clk);
      guard++;
    end
    m_ready = 1'b0;
    total++;
    if (guard >= 2000 || !side_ok) begin
      bad++;
      $display("FAIL %s drain_phase: beats %0d of %0d side_ok=%0d", tag, got, NB_OUT, side_ok);
    end
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s drain_end: m_valid=%b busy=%b s_ready=%b exp 0 0 1", tag, m_valid, busy, s_ready);
    end
  endtask

  task automatic decode_frame(input int f, input int term_at, input bit bp, input string tag);
    int n;
    int exp_n;
    bit exp_conv;
    exp_conv = (term_at >= 1 && term_at <= MAX_ITER);
    exp_n = exp_conv ? term_at : MAX_ITER;
    check_loaded(f, tag);
    run_core(f, term_at, n);
    total++;
    if (n != exp_n) begin
      bad++;
      $display("FAIL %s en_cycles: got %0d exp %0d", tag, n, exp_n);
    end
`ifdef LDPC_CTRL_STATS_EN
    total++;
    if (stat_iter !== 8'(exp_n) || stat_conv !== exp_conv) begin
      bad++;
      $display("FAIL %s stats: got iter=%0d conv=%b exp iter=%0d conv=%b", tag, stat_iter, stat_conv, exp_n, exp_conv);
    end
`endif
    drain(f, bp, tag);
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    core_term = 1'b0; core_res = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (s_ready !== 1'b0 || core_rst !== 1'b1 || core_en !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: rdy=%b rst=%b en=%b busy=%b exp 0 1 0 0", s_ready, core_rst, core_en, busy);
    end
    total++;
    if (m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0 || frm_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: mv=%b md=%h ml=%b err=%b exp 0 0 0 0", m_valid, m_data, m_last, frm_err);
    end
    total++;
    if (core_l !== '0) begin
      bad++;
      $display("FAIL reset_core_l: got nonzero exp 0");
    end
`ifdef LDPC_CTRL_STATS_EN
    total++;
    if (stat_iter !== 8'd0 || stat_conv !== 1'b0) begin
      bad++;
      $display("FAIL reset_stats: got %0d/%b exp 0/0", stat_iter, stat_conv);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: rdy=%b busy=%b exp 1 0", s_ready, busy);
    end
  endtask

  task automatic test_nominal();
    fill_frame(0);
    send_frame(0, NB_IN, NB_IN - 1, 1'b0, 0);
    decode_frame(0, 7, 1'b0, "nominal");
  endtask

  task automatic test_cap();
    fill_frame(0);
    send_frame(0, NB_IN, NB_IN - 1, 1'b0, 0);
    decode_frame(0, 0, 1'b0, "cap");
  endtask

  task automatic test_framing(input int nbeats, input int last_at, input string tag);
    fill_frame(0);
    send_frame(0, nbeats, last_at, 1'b0, 0);
    total++;
    if (frm_err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s err_pulse: err=%b busy=%b rdy=%b exp 1 0 1", tag, frm_err, busy, s_ready);
    end
    @(negedge clk);
    total++;
    if (frm_err !== 1'b0) begin
      bad++;
      $display("FAIL %s err_width: got %b exp 0", tag, frm_err);
    end
    fill_frame(0);
    send_frame(0, NB_IN, NB_IN - 1, 1'b0, 0);
    decode_frame(0, int'($urandom_range(1, 30)), 1'b0, tag);
  endtask

  task automatic test_backpressure();
    fill_frame(1);
    send_frame(1, NB_IN, NB_IN - 1, 1'b0, 0);
    decode_frame(1, int'($urandom_range(1, 20)), 1'b1, "backpressure");
  endtask

  task automatic test_back_to_back();
    fill_frame(0);
    fill_frame(1);
    send_frame(0, NB_IN, NB_IN - 1, 1'b1, 1);
    decode_frame(0, int'($urandom_range(2, 15)), 1'b1, "b2b_first");
    send_frame(1, NB_IN, NB_IN - 1, 1'b0, 0);
    decode_frame(1, int'($urandom_range(2, 15)), 1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid_run();
    fill_frame(0);
    send_frame(0, NB_IN, NB_IN - 1, 1'b0, 0);
    check_loaded(0, "mid_run");
    core_res = res_v[0];
    repeat (5) @(negedge clk);
    total++;
    if (core_en !== 1'b1) begin
      bad++;
      $display("FAIL mid_run_running: core_en=%b exp 1", core_en);
    end
    rst = 1'b1;
    #1;
    total++;
    if (core_rst !== 1'b1 || core_en !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 ||
        m_valid !== 1'b0 || frm_err !== 1'b0 || core_l !== '0) begin
      bad++;
      $display("FAIL mid_run_reset: rst=%b en=%b busy=%b rdy=%b mv=%b err=%b l_zero=%b exp 1 0 0 0 0 0 1",
               core_rst, core_en, busy, s_ready, m_valid, frm_err, core_l == '0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_run_recover: rdy=%b busy=%b exp 1 0", s_ready, busy);
    end
    fill_frame(1);
    send_frame(1, NB_IN, NB_IN - 1, 1'b0, 0);
    decode_frame(1, 3, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_cap();
    test_framing(101, 100, "early_last");
    test_framing(NB_IN, -1, "late_last");
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
